// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Purpose : Shared types for the cache/memory arbitration slice.
//           word_t      - 32-bit address/data word
//           ramstate_t  - status reported by the RAM model
//           arb_state_t - arbiter FSM states
// Ports   : none (package)
// -----------------------------------------------------------------------------
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// -----------------------------------------------------------------------------
// starve_counter
// Purpose : Saturating up-counter used to bound how many dcache grants may be
//           issued while the icache is left waiting.
// Ports   : i_clk  - clock, rising edge
//           i_nrst - synchronous active-low reset
//           i_inc  - count one more dcache grant (ignored once saturated)
//           i_clr  - clear to zero (wins over i_inc)
//           o_sat  - counter has reached MAX
// -----------------------------------------------------------------------------
module starve_counter #(
   parameter int MAX   = 4,
   parameter int CNT_W = $clog2(MAX + 1)
) (
   input  logic i_clk,
   input  logic i_nrst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_sat
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_sat;

   assign w_sat = (r_cnt == CNT_W'(MAX));
   assign o_sat = w_sat;

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_sat) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Purpose : Shares one RAM port between the icache fill path and the dcache
//           fill/writeback path. One requester is latched per transaction and
//           keeps the grant until RAM reports ACCESS. The dcache has priority;
//           a starvation counter forces an icache grant after STARVE_MAX
//           dcache grants taken while the icache was pending.
// Ports   : CLK, nRST                    - clock, sync active-low reset
//           iREN, iaddr / iload, iwait   - icache read request / response
//           dREN, dWEN, daddr, dstore    - dcache read/write request
//           dload, dwait                 - dcache response
//           ramREN, ramWEN, ramaddr,
//           ramstore                     - RAM command
//           ramload, ramstate            - RAM response and status
// -----------------------------------------------------------------------------
module cache_mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [ADDR_W-1:0] iload,
   output logic              iwait,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [ADDR_W-1:0] dstore,
   output logic [ADDR_W-1:0] dload,
   output logic              dwait,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [ADDR_W-1:0] ramstore,
   input  logic [ADDR_W-1:0] ramload,
   input  logic [1:0]        ramstate
);

   arb_state_t r_state;
   ramstate_t  w_ramstate;
   logic       w_dreq;
   logic       w_access;
   logic       w_sat;
   logic       w_go_d;
   logic       w_inc;
   logic       w_clr;

   assign w_ramstate = ramstate_t'(ramstate);
   assign w_access   = (w_ramstate == ACCESS);
   assign w_dreq     = dREN | dWEN;

   // dcache wins unless the icache is waiting and has already been passed
   // over STARVE_MAX times.
   assign w_go_d = w_dreq && !(iREN && w_sat);

   // Count a dcache grant only when it actually overtakes a waiting icache.
   assign w_inc = (r_state == IDLE) && w_go_d && iREN;
   assign w_clr = ((r_state == IDLE) && !iREN) ||
                  ((r_state == IGRANT) && iREN && w_access);

   starve_counter #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .i_clk  (CLK),
      .i_nrst (nRST),
      .i_inc  (w_inc),
      .i_clr  (w_clr),
      .o_sat  (w_sat)
   );

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_go_d) begin
                  r_state <= DGRANT;
               end else if (iREN) begin
                  r_state <= IGRANT;
               end
            end
            // A dropped request also releases the grant so a misbehaving
            // requester can never lock the RAM port.
            DGRANT: begin
               if (!w_dreq || w_access) begin
                  r_state <= IDLE;
               end
            end
            IGRANT: begin
               if (!iREN || w_access) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iload    = '0;
      dload    = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      case (r_state)
         DGRANT: begin
            // Illegal dREN&dWEN resolves to a write.
            ramREN   = dREN & ~dWEN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            dload    = ramload;
            dwait    = ~(w_access & w_dreq);
         end
         IGRANT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            iload   = ramload;
            iwait   = ~(w_access & iREN);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

   localparam int STARVE_MAX = 4;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        iwait, dwait, ramREN, ramWEN;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] ref_mem [16];

   always #5 CLK = ~CLK;

   cache_mem_arbiter #(
      .STARVE_MAX (STARVE_MAX),
      .ADDR_W     (32)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iload    (iload),
      .iwait    (iwait),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dload    (dload),
      .dwait    (dwait),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
   );

   // Inputs are driven just after the rising edge, outputs sampled at the
   // falling edge of the same cycle.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      @(negedge CLK);
   endtask

   task automatic idle_inputs();
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0;
      ramload = '0; ramstate = 2'd0;
   endtask

   task automatic new_d_req();
      dWEN   = 1'($urandom_range(0, 1));
      dREN   = ~dWEN;
      daddr  = {28'd0, 4'($urandom)};
      dstore = $urandom;
   endtask

   task automatic test_reset();
      idle_inputs();
      nRST = 1'b0; iREN = 1'b1; dREN = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         settle();
         n_tests++;
         if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_ctrl cyc%0d: got %b want 0011", c, {ramREN, ramWEN, iwait, dwait});
         end
         n_tests++;
         if ({iload, dload, ramaddr, ramstore} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data cyc%0d: got %h want 0", c, {iload, dload, ramaddr, ramstore});
         end
      end
      step();
      idle_inputs();
      nRST = 1'b1;
      settle();
      $display("[TB] reset checked");
   endtask

   task automatic test_lone_icache();
      step(); iREN = 1'b1; iaddr = 32'h100; ramstate = 2'd0; settle();
      n_tests++;
      if ({ramREN, iwait} !== 2'b01) begin
         n_fail++; $display("FAIL lone_arb: got ramREN,iwait=%b want 01", {ramREN, iwait});
      end
      step(); ramstate = 2'd1; settle();
      n_tests++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h100 || iwait !== 1'b1) begin
         n_fail++; $display("FAIL lone_busy: got ren=%b addr=%h iwait=%b want 1 100 1", ramREN, ramaddr, iwait);
      end
      step(); ramstate = 2'd2; ramload = 32'hDEADBEEF; settle();
      n_tests++;
      if (iwait !== 1'b0 || iload !== 32'hDEADBEEF || ramaddr !== 32'h100) begin
         n_fail++; $display("FAIL lone_access: got iwait=%b iload=%h addr=%h want 0 deadbeef 100", iwait, iload, ramaddr);
      end
      step(); iREN = 1'b0; ramstate = 2'd0; settle();
      n_tests++;
      if (iwait !== 1'b1 || ramREN !== 1'b0 || iload !== 32'd0) begin
         n_fail++; $display("FAIL lone_after: got iwait=%b ren=%b iload=%h want 1 0 0", iwait, ramREN, iload);
      end
      $display("[TB] lone icache read addr=100 data=deadbeef");
   endtask

   task automatic test_simultaneous();
      step();
      iREN = 1'b1; iaddr = 32'h300;
      dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678;
      settle();
      n_tests++;
      if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
         n_fail++; $display("FAIL simul_arb: got %b want 0011", {ramREN, ramWEN, iwait, dwait});
      end
      step(); ramstate = 2'd2; ramload = 32'hA5A5A5A5; settle();
      n_tests++;
      if ({ramREN, ramWEN, dwait, iwait} !== 4'b0101 || ramaddr !== 32'h200 || ramstore !== 32'h12345678 || iload !== 32'd0) begin
         n_fail++;
         $display("FAIL simul_dgrant: got ren,wen,dw,iw=%b addr=%h store=%h iload=%h want 0101 200 12345678 0",
                  {ramREN, ramWEN, dwait, iwait}, ramaddr, ramstore, iload);
      end
      step(); dWEN = 1'b0; ramstate = 2'd0; settle();
      n_tests++;
      if ({ramREN, iwait} !== 2'b01) begin
         n_fail++; $display("FAIL simul_gap: got ren,iwait=%b want 01", {ramREN, iwait});
      end
      step(); ramstate = 2'd2; ramload = 32'h0BADF00D; settle();
      n_tests++;
      if ({ramREN, iwait, dwait} !== 3'b101 || ramaddr !== 32'h300 || iload !== 32'h0BADF00D || dload !== 32'd0) begin
         n_fail++;
         $display("FAIL simul_igrant: got ren,iw,dw=%b addr=%h iload=%h dload=%h want 101 300 0badf00d 0",
                  {ramREN, iwait, dwait}, ramaddr, iload, dload);
      end
      step(); idle_inputs(); settle();
      $display("[TB] simultaneous: D wr 200 then I rd 300");
   endtask

   task automatic test_ram_error();
      step(); dREN = 1'b1; daddr = 32'h40; settle();
      for (int k = 0; k < 7; k++) begin
         step(); ramstate = (k < 5) ? 2'd1 : 2'd3; ramload = $urandom; settle();
         n_tests++;
         if ({dwait, ramREN, iwait} !== 3'b111 || ramaddr !== 32'h40) begin
            n_fail++; $display("FAIL err_hold k=%0d: got dw,ren,iw=%b addr=%h want 111 40", k, {dwait, ramREN, iwait}, ramaddr);
         end
      end
      step(); ramstate = 2'd2; ramload = 32'hCAFEF00D; settle();
      n_tests++;
      if (dwait !== 1'b0 || dload !== 32'hCAFEF00D) begin
         n_fail++; $display("FAIL err_done: got dwait=%b dload=%h want 0 cafef00d", dwait, dload);
      end
      step(); idle_inputs(); settle();
      $display("[TB] busy/error retry: D rd 40 data=cafef00d");
   endtask

   task automatic test_illegal_both();
      step(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h55; dstore = 32'h77; settle();
      step(); ramstate = 2'd2; settle();
      n_tests++;
      if ({ramREN, ramWEN, dwait} !== 3'b010 || ramstore !== 32'h77) begin
         n_fail++; $display("FAIL illegal_both: got ren,wen,dw=%b store=%h want 010 77", {ramREN, ramWEN, dwait}, ramstore);
      end
      step(); idle_inputs(); settle();
      $display("[TB] dREN&dWEN treated as write addr=55");
   endtask

   task automatic test_reset_mid();
      step(); dREN = 1'b1; daddr = 32'h80; settle();
      step(); ramstate = 2'd1; settle();
      n_tests++;
      if (ramREN !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_grant: got ramREN=%b want 1", ramREN);
      end
      step(); nRST = 1'b0; settle();
      step(); nRST = 1'b1; settle();
      n_tests++;
      if ({ramREN, ramWEN, dwait} !== 3'b001) begin
         n_fail++; $display("FAIL rstmid_idle: got ren,wen,dw=%b want 001", {ramREN, ramWEN, dwait});
      end
      step(); ramstate = 2'd2; ramload = 32'h11; settle();
      n_tests++;
      if ({ramREN, dwait} !== 2'b10 || dload !== 32'h11) begin
         n_fail++; $display("FAIL rstmid_rearb: got ren,dw=%b dload=%h want 10 11", {ramREN, dwait}, dload);
      end
      step(); idle_inputs(); settle();
      $display("[TB] reset mid-transaction, D rd 80 re-arbitrated");
   endtask

   task automatic test_drop();
      step(); dREN = 1'b1; daddr = 32'h90; settle();
      step(); ramstate = 2'd1; settle();
      step(); dREN = 1'b0; settle();
      step(); ramstate = 2'd2; settle();
      n_tests++;
      if ({ramREN, ramWEN, dwait} !== 3'b001) begin
         n_fail++; $display("FAIL drop_idle: got ren,wen,dw=%b want 001", {ramREN, ramWEN, dwait});
      end
      step(); ramstate = 2'd0; dREN = 1'b1; settle();
      step(); ramstate = 2'd2; ramload = 32'h99; settle();
      n_tests++;
      if (dwait !== 1'b0 || dload !== 32'h99) begin
         n_fail++; $display("FAIL drop_recover: got dwait=%b dload=%h want 0 99", dwait, dload);
      end
      step(); idle_inputs(); settle();
      $display("[TB] dropped request recovered");
   endtask

   // Both requesters (or only the dcache) keep a request up at all times with
   // random addresses/ops and random RAM latency. Expected service order:
   // STARVE_MAX dcache completions then one icache completion, repeating.
   task automatic test_back_to_back(input bit with_i, input int n_done);
      int done = 0;
      int d_run = 0;
      int cyc = 0;
      int lat;
      bit exp_i;
      step();
      new_d_req();
      iREN = with_i; iaddr = {28'd0, 4'($urandom)};
      ramstate = 2'd0;
      lat = $urandom_range(0, 3);
      settle();
      while (done < n_done && cyc < 2000) begin
         step();
         cyc++;
         if (ramREN || ramWEN) begin
            if (lat == 0) begin
               ramstate = 2'd2;
               ramload  = ramREN ? ref_mem[ramaddr[3:0]] : $urandom;
            end else begin
               ramstate = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd3;
               lat--;
            end
         end else begin
            ramstate = 2'd0;
         end
         settle();
         exp_i = with_i && (d_run == STARVE_MAX);
         if (!dwait && !iwait) begin
            n_tests++; n_fail++;
            $display("FAIL b2b_both_done: got dwait=0 iwait=0 want only one low");
            done++;
         end else if (!dwait) begin
            n_tests++;
            if (exp_i) begin
               n_fail++; $display("FAIL b2b_order #%0d: got D want I", done);
            end
            n_tests++;
            if (dWEN) begin
               if (ramWEN !== 1'b1 || ramstore !== dstore || ramaddr !== daddr) begin
                  n_fail++; $display("FAIL b2b_dwr: got wen=%b addr=%h store=%h want 1 %h %h", ramWEN, ramaddr, ramstore, daddr, dstore);
               end
               ref_mem[daddr[3:0]] = dstore;
               $display("[TB] D wr addr=%h data=%h", daddr, dstore);
            end else begin
               if (dload !== ref_mem[daddr[3:0]]) begin
                  n_fail++; $display("FAIL b2b_drd: got dload=%h want %h", dload, ref_mem[daddr[3:0]]);
               end
               $display("[TB] D rd addr=%h data=%h", daddr, dload);
            end
            d_run++;
            done++;
            new_d_req();
            lat = $urandom_range(0, 3);
         end else if (!iwait) begin
            n_tests++;
            if (!exp_i) begin
               n_fail++; $display("FAIL b2b_order #%0d: got I want D (d_run=%0d)", done, d_run);
            end
            n_tests++;
            if (iload !== ref_mem[iaddr[3:0]]) begin
               n_fail++; $display("FAIL b2b_ird: got iload=%h want %h", iload, ref_mem[iaddr[3:0]]);
            end
            $display("[TB] I rd addr=%h data=%h", iaddr, iload);
            d_run = 0;
            done++;
            iaddr = {28'd0, 4'($urandom)};
            lat = $urandom_range(0, 3);
         end
      end
      n_tests++;
      if (done < n_done) begin
         n_fail++; $display("FAIL b2b_timeout: got %0d completions want %0d", done, n_done);
      end
      step(); idle_inputs(); settle();
      step(); settle();
   endtask

   initial begin
      for (int k = 0; k < 16; k++) ref_mem[k] = $urandom;
      test_reset();
      test_lone_icache();
      test_simultaneous();
      test_ram_error();
      test_illegal_both();
      test_reset_mid();
      test_drop();
      test_back_to_back(1'b0, 12);
      test_back_to_back(1'b1, 25);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single RAM port between the icache fill path and the dcache fill/writeback path. It sits between the cache block and the memory/RAM model. It latches one requester per transaction and holds that grant until RAM reports ACCESS. The dcache has priority, and a starvation counter bounds how long the icache can wait.

Parameters:
STARVE_MAX, 4, consecutive dcache grants allowed while icache is pending before icache is forced next
ADDR_W, 32, width of address and data words (word_t)

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  synchronous active-low reset
iREN  input  1  icache read request
iaddr  input  32  icache word address
iload  output  32  read data to icache
iwait  output  1  icache stall; 0 only in the cycle its transfer completes
dREN  input  1  dcache read request
dWEN  input  1  dcache write request (dREN&dWEN is illegal)
daddr  input  32  dcache word address
dstore  input  32  dcache write data
dload  output  32  read data to dcache
dwait  output  1  dcache stall; 0 only in the cycle its transfer completes
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Clock and reset: single clock CLK. Reset nRST is synchronous and active-low.
- Reset state: state=IDLE, starve_cnt=0. All outputs are 0 except iwait=1 and dwait=1.
- FSM states: IDLE, DGRANT, IGRANT.
- IDLE:
  - If (dREN|dWEN) and not (iREN and starve_cnt==STARVE_MAX): go to DGRANT.
  - Else if iREN: go to IGRANT.
  - Else stay in IDLE.
- IDLE drives no RAM enables. iwait=dwait=1 whenever the requester is not granted.
- Latching: the grant decision is registered. Minimum latency from request to completion is 2 cycles (arbitration cycle plus the ACCESS cycle).
- Requesters must hold their request and address stable until their wait signal drops.
- DGRANT:
  - Drive ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore, dload=ramload.
  - When ramstate==ACCESS: dwait=0 for that cycle, then go to IDLE.
  - If iREN was pending at grant time, starve_cnt increments, saturating at STARVE_MAX.
- IGRANT:
  - Drive ramREN=1, ramWEN=0, ramaddr=iaddr, iload=ramload.
  - When ramstate==ACCESS: iwait=0 for that cycle, then go to IDLE, and starve_cnt clears to 0.
- Starvation counter: starve_cnt also clears whenever iREN is low in IDLE.
- Back-to-back requests: with both requesters active continuously, the grant pattern is STARVE_MAX dcache transactions followed by 1 icache transaction, repeating.
- Request dropped mid-grant: if the requester deasserts before ACCESS, return to IDLE next cycle with RAM enables low. This is a protocol violation, but it must not deadlock.
- ERROR or BUSY: the grant is held and the requester stays stalled. ERROR is treated as a retry, with no timeout.
- Unselected data outputs: iload and dload are 0 when not granted.
- Mid-transaction reset: nRST low mid-transaction returns to IDLE on the next edge. The RAM enables drop in that same cycle.
- Illegal dREN&dWEN: the write takes precedence (ramREN=0).

Decomposition:
- Shared package cpu_types_pkg:
  - word_t
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR)
  - arb_state_t enum (IDLE, DGRANT, IGRANT)
- Sub-module starve_counter: saturating counter with inc/clr/sat.

Test Plan:
- Reset: hold nRST=0 for 2 cycles while iREN=dREN=1 -> ramREN=ramWEN=0, iwait=dwait=1, state IDLE.
- Lone icache read: iREN=1, iaddr=0x100, RAM returns ACCESS in cycle 3 with ramload=0xDEADBEEF -> ramaddr=0x100, iload=0xDEADBEEF, iwait=0 exactly in cycle 3.
- Simultaneous request: iREN and dWEN (daddr=0x200, dstore=0x12345678) rise together -> dcache granted first with ramWEN=1 and ramstore=0x12345678; icache is granted only after dwait pulses low.
- Starvation bound: STARVE_MAX=4, dREN held continuously, iREN held -> exactly 4 dcache completions, then 1 icache completion, pattern repeats.
- RAM error: BUSY for 5 cycles, then ERROR for 2, then ACCESS -> wait stays high for all 7 cycles, grant never switches, completion on ACCESS.
- Reset mid-transaction: nRST=0 during DGRANT with ramstate=BUSY -> next cycle RAM enables are 0 and dwait=1; after reset, a pending request is re-arbitrated from IDLE.
